mon_c2sif: RTL and testbench

MON_C2SIF -- requirements
Module: mon_c2sif

---
 rtl/mon_c2sif.sv | 149 ++++++++++++++
 tb/tb_mon_c2sif.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mon_c2sif.sv
// Output-pin edge monitor. It records level changes of dout into a FIFO that is read over c2sif.
// Define MON_C2SIF_TSTAMP_EN to add a 31-bit timestamp counter and store timestamps in the records.
module mon_c2sif #(
    parameter int unsigned ID    = 0,
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dout,
    input  logic        req,
    input  logic [7:0]  id,
    input  logic [1:0]  fn,
    output logic        ack,
    output logic [31:0] data,
    output logic [1:0]  ret
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);
`ifdef MON_C2SIF_TSTAMP_EN
    localparam int unsigned RW = 32;
`else
    localparam int unsigned RW = 1;
`endif

    typedef enum logic [1:0] {StIdle, StResp, StWaitLo} state_e;

    state_e        state_q;
    logic          sync1_q, sync2_q, lvl_q, ovf_q;
    logic [AW:0]   wr_ptr_q, rd_ptr_q, count;
    logic [RW-1:0] mem_q [DEPTH];
    logic [RW-1:0] rec_new, rec_head;
    logic [31:0]   pop_data;
    logic [7:0]    count8;
    logic          edge_det, exec, do_pop, do_clr, empty, full, pop_ok, push_ok;

    assign edge_det = (sync2_q != lvl_q);
    assign exec     = (state_q == StIdle) && req && (id == 8'(ID));
    assign do_pop   = exec && (fn == 2'd1);
    assign do_clr   = exec && (fn == 2'd3);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign count8   = 8'(count);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok   = do_pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok  = edge_det && !do_clr && (!full || pop_ok);
    assign rec_head = mem_q[rd_ptr_q[AW-1:0]];

`ifdef MON_C2SIF_TSTAMP_EN
    logic [30:0] tstamp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tstamp_q <= '0;
        end else begin
            tstamp_q <= tstamp_q + 31'd1;
        end
    end

    assign rec_new  = {sync2_q, tstamp_q};
    assign pop_data = rec_head;
`else
    assign rec_new  = sync2_q;
    assign pop_data = {rec_head, 31'b0};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
        end else begin
            sync1_q <= dout;
            sync2_q <= sync1_q;
            if (edge_det) lvl_q <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else if (do_clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (pop_ok)               rd_ptr_q <= rd_ptr_q + PtrOne;
            if (push_ok)              wr_ptr_q <= wr_ptr_q + PtrOne;
            if (edge_det && !push_ok) ovf_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= rec_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ack     <= 1'b0;
            data    <= '0;
            ret     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req && id == 8'(ID)) begin
                        ack     <= 1'b1;
                        state_q <= StResp;
                        case (fn)
                            2'd0: begin
                                data <= {31'b0, lvl_q};
                                ret  <= 2'd0;
                            end
                            2'd1: begin
                                data <= empty ? 32'd0 : pop_data;
                                ret  <= empty ? 2'd1 : 2'd0;
                            end
                            2'd2: begin
                                data <= {ovf_q, 7'b0, count8, full, empty, 6'b0, 8'(DEPTH - 1)};
                                ret  <= 2'd0;
                            end
                            default: begin
                                data <= '0;
                                ret  <= 2'd0;
                            end
                        endcase
                    end else if (req) begin
                        state_q <= StWaitLo;
                    end
                end
                StResp: begin
                    if (!req) begin
                        ack     <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StWaitLo: begin
                    if (!req) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mon_c2sif.sv
// Scoreboard bench for mon_c2sif: a cycle model predicts each c2sif response at the request edge.
// Responses are queued there and then compared when ack rises.
module tb_mon_c2sif;

    localparam int unsigned ID    = 3;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n, dout, req;
    logic [7:0]  id;
    logic [1:0]  fn;
    logic        ack;
    logic [31:0] data;
    logic [1:0]  ret;

    mon_c2sif #(.ID(ID), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .dout (dout),
        .req  (req),
        .id   (id),
        .fn   (fn),
        .ack  (ack),
        .data (data),
        .ret  (ret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
    } resp_t;

    int          total = 0;
    int          bad   = 0;
    resp_t       exp_q[$];
    logic [31:0] mq[$];
    logic        m1, m2, mlvl, movf, mack, ack_prev;
    logic [30:0] mts;
    int          mst;
    logic [31:0] last_data;
    logic [1:0]  last_ret;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m1 = 0; m2 = 0; mlvl = 0; mts = '0; movf = 0; mst = 0; mack = 0;
        mq.delete();
        exp_q.delete();
    endtask

    task automatic model_edge();
        logic        push, ex;
        logic [31:0] rec;
        logic [7:0]  cnt8;
        resp_t       rs;
        push = (m2 != mlvl);
        ex   = (mst == 0) && req && (id == 8'(ID));
`ifdef MON_C2SIF_TSTAMP_EN
        rec = {m2, mts};
`else
        rec = {m2, 31'b0};
`endif
        if (ex) begin
            rs = '0;
            case (fn)
                2'd0: rs.d = {31'b0, mlvl};
                2'd1: begin
                    if (mq.size() > 0) rs.d = mq[0];
                    else rs.r = 2'd1;
                end
                2'd2: begin
                    cnt8 = 8'(mq.size());
                    rs.d = {movf, 7'b0, cnt8, mq.size() == DEPTH, mq.size() == 0, 6'b0,
                            8'(DEPTH - 1)};
                end
                default: rs.d = '0;
            endcase
            exp_q.push_back(rs);
        end
        if (ex && fn == 2'd3) begin
            mq.delete();
            movf = 0;
        end else begin
            if (ex && fn == 2'd1 && mq.size() > 0) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(rec);
                else movf = 1;
            end
        end
        case (mst)
            0: if (req) begin
                if (id == 8'(ID)) begin mst = 1; mack = 1; end
                else mst = 2;
            end
            1: if (!req) begin mst = 0; mack = 0; end
            default: if (!req) mst = 0;
        endcase
        if (push) mlvl = m2;
        m2  = m1;
        m1  = dout;
        mts = mts + 31'd1;
    endtask

    task automatic step();
        resp_t rs;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check("ack", ack, mack);
        if (ack && !ack_prev) begin
            check("sb_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                rs = exp_q.pop_front();
                check("resp_data", data, rs.d);
                check("resp_ret", ret, rs.r);
            end
            last_data = data;
            last_ret  = ret;
        end
        ack_prev = ack;
    endtask

    task automatic xact(input logic [7:0] idv, input logic [1:0] fnv, input int hold);
        req = 1; id = idv; fn = fnv;
        repeat (hold) step();
        req = 0;
        repeat (2) step();
    endtask

    task automatic toggle();
        dout = ~dout;
        step();
        step();
    endtask

    initial begin
        rst_n = 0; dout = 0; req = 0; id = '0; fn = '0; ack_prev = 0;
        last_data = '0; last_ret = '0;
        model_reset();
        #12;
        check("rst_ack0", ack, 0);
        check("rst_data0", data, 0);
        check("rst_ret0", ret, 0);
        @(posedge clk);
        #1 rst_n = 1;

        // Rising edge during the cycle with tstamp 10 is stored with timestamp 12.
        repeat (10) step();
        dout = 1;
        repeat (4) step();
        xact(8'(ID), 2'd1, 1);
`ifdef MON_C2SIF_TSTAMP_EN
        check("ts_pop", last_data, 32'h8000_000C);
`else
        check("ts_pop", last_data, 32'h8000_0000);
`endif
        check("ts_ret", last_ret, 0);

        // Overflow: 20 edges into a 16-deep FIFO.
        xact(8'(ID), 2'd3, 1);
        repeat (20) toggle();
        repeat (3) step();
        xact(8'(ID), 2'd2, 1);
        check("st_ovf", last_data[31], 1);
        check("st_cnt", last_data[23:16], 16);
        check("st_full", last_data[15], 1);
        check("st_empty", last_data[14], 0);
        check("st_depth", last_data[7:0], DEPTH - 1);
        repeat (16) xact(8'(ID), 2'd1, 1);
        check("pop16_lvl", last_data[31], 1);
        xact(8'(ID), 2'd1, 1);
        check("pop17_ret", last_ret, 1);
        check("pop17_data", last_data, 0);

        // Foreign id held high is ignored; held matching req is answered once.
        xact(8'(ID + 1), 2'd3, 5);
        xact(8'(ID), 2'd2, 1);
        check("wid_ovf", last_data[31], 1);
        check("wid_empty", last_data[14], 1);
        xact(8'(ID), 2'd0, 6);
        check("lvl", last_data, {31'b0, dout});

        // Push and pop on the same edge with an empty FIFO.
        dout = ~dout;
        step();
        step();
        req = 1; id = 8'(ID); fn = 2'd1;
        step();
        req = 0;
        repeat (2) step();
        check("pp_ret", last_ret, 1);
        xact(8'(ID), 2'd1, 1);
        check("pp2_ret", last_ret, 0);
        check("pp2_lvl", last_data[31], dout);

        // Push and clear on the same edge: clear wins.
        dout = ~dout;
        step();
        step();
        req = 1; id = 8'(ID); fn = 2'd3;
        step();
        req = 0;
        repeat (2) step();
        xact(8'(ID), 2'd2, 1);
        check("clr_empty", last_data[14], 1);

        // Reset while ack is high; req stays high and is served again after release.
        dout = 1;
        req = 1; id = 8'(ID); fn = 2'd2;
        step();
        check("pre_rst_ack", ack, 1);
        rst_n = 0;
        #1;
        check("rst_ack", ack, 0);
        check("rst_data", data, 0);
        check("rst_ret", ret, 0);
        model_reset();
        ack_prev = 0;
        #2 rst_n = 1;
        step();
        req = 0;
        repeat (2) step();
        check("rel_empty", last_data[14], 1);
        check("rel_ovf", last_data[31], 0);
        xact(8'(ID), 2'd1, 1);
        check("rel_ret", last_ret, 0);
        check("rel_lvl", last_data[31], 1);

        check("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
